// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
//
// Round-robin arbiter that merges N_IN valid/ready streams into one output
// stream. A requester holds the grant for up to MAX_BURST accepted beats, or
// until it drops valid. The grant then passes on, and the scan for the next
// grant starts at the channel after the one just served. Accepted beats go
// into a two-entry buffer (head + skid), so the input side never depends
// combinationally on out_ready.
//
// Parameters
//   N_IN       number of requester channels (2..16)
//   DATA_W     payload width per channel
//   MAX_BURST  maximum beats accepted per grant (1..255)
//
// Ports
//   clk              single clock, all state on the rising edge
//   rst              asynchronous, active-high reset
//   in_valid[N_IN]   per-requester beat valid
//   in_ready[N_IN]   per-requester accept (only the granted channel can be high)
//   in_data          payloads, channel i at bits [i*DATA_W +: DATA_W]
//   enable_transfer  high permits acceptance and new grants
//   out_valid        head beat valid
//   out_ready        downstream accept
//   out_data         head beat payload
//   out_src          source channel of head beat
//   busy             high while a grant is held or the buffer is non-empty
// -----------------------------------------------------------------------------
module stream_rr_arbiter #(
  parameter  int N_IN      = 4,
  parameter  int DATA_W    = 32,
  parameter  int MAX_BURST = 4,
  localparam int SRC_W     = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN-1:0]        in_valid,
  output logic [N_IN-1:0]        in_ready,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic                   enable_transfer,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SRC_W-1:0]       out_src,
  output logic                   busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // burst_cnt holds the last beat number before the grant is released.
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_t             state;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   rr_ptr;
  logic [7:0]         burst_cnt;

  logic [DATA_W-1:0]  head_data;
  logic [SRC_W-1:0]   head_src;
  logic [DATA_W-1:0]  skid_data;
  logic [SRC_W-1:0]   skid_src;
  logic [1:0]         count;

  logic               sel_found;
  logic [SRC_W-1:0]   sel_idx;
  logic               in_xfer;
  logic               out_xfer;
  logic [DATA_W-1:0]  grant_data;

  // Channel index (base + k) mod N_IN. Both operands are below N_IN, so one
  // conditional subtract is enough.
  function automatic logic [SRC_W-1:0] rotate_idx(input logic [SRC_W-1:0] base,
                                                  input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= N_IN) sum = sum - N_IN;
    return SRC_W'(sum);
  endfunction

  // Channel after the current grant, wrapping at N_IN (N_IN need not be a
  // power of two).
  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
    if (int'(idx) == N_IN - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Round-robin pick: the first asserted in_valid found scanning from rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (!sel_found && in_valid[rotate_idx(rr_ptr, k)]) begin
        sel_found = 1'b1;
        sel_idx   = rotate_idx(rr_ptr, k);
      end
    end
  end

  // Only the granted channel is offered ready. Gating on count < 2, and not on
  // out_ready, is what keeps the input side free of any path from downstream.
  always_comb begin
    in_ready = '0;
    if ((state == GRANT) && enable_transfer && (count != 2'd2))
      in_ready[grant_idx] = 1'b1;
  end

  assign in_xfer    = |(in_valid & in_ready);
  assign out_valid  = (count != 2'd0);
  assign out_xfer   = out_valid & out_ready;
  assign grant_data = in_data[grant_idx*DATA_W +: DATA_W];
  assign out_data   = head_data;
  assign out_src    = head_src;
  assign busy       = (state == GRANT) || (count != 2'd0);

  // Grant FSM. While enable_transfer is low in GRANT everything is frozen;
  // the downstream buffer keeps draining independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_transfer && sel_found) begin
            grant_idx <= sel_idx;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (enable_transfer) begin
            if (!in_valid[grant_idx]) begin
              state  <= IDLE;
              rr_ptr <= next_idx(grant_idx);
            end else if (in_xfer) begin
              burst_cnt <= burst_cnt + 8'd1;
              if (burst_cnt == BURST_LAST) begin
                state  <= IDLE;
                rr_ptr <= next_idx(grant_idx);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry FIFO. The head is always the oldest beat. A push goes into the
  // head when the FIFO is empty or being emptied this cycle, otherwise into
  // the skid slot. A pop moves the skid beat forward. A push together with a
  // pop cannot happen at count 2, because in_ready is low there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data <= '0;
      head_src  <= '0;
      skid_data <= '0;
      skid_src  <= '0;
      count     <= 2'd0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10: begin
          if (count == 2'd0) begin
            head_data <= grant_data;
            head_src  <= grant_idx;
          end else begin
            skid_data <= grant_data;
            skid_src  <= grant_idx;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= skid_data;
          head_src  <= skid_src;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_data <= grant_data;
            head_src  <= grant_idx;
          end else begin
            head_data <= skid_data;
            head_src  <= skid_src;
            skid_data <= grant_data;
            skid_src  <= grant_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_rr_arbiter
//
// Directed bench for stream_rr_arbiter with N_IN=4, DATA_W=8, MAX_BURST=4.
// Each step drives the inputs just after a falling edge. It then checks the
// outputs for that cycle before the next rising edge.
//
// The table section drives channel c with the byte {c[1:0], step[5:0]}. This
// means every beat carries both its source and the cycle in which it was
// accepted. The hand-written sequences drive the same byte on all channels.
// -----------------------------------------------------------------------------
module tb_stream_rr_arbiter;

  localparam int N_IN      = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [31:0] in_data = '0;
  logic        enable_transfer = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       r;
    logic [3:0] v;
    logic       e;
    logic       o;
    logic [3:0] ei;
    logic       eov;
    logic [7:0] eod;
    logic [1:0] eos;
    logic       eb;
  } vec_t;

  vec_t vecs[$];

  stream_rr_arbiter #(
    .N_IN(N_IN),
    .DATA_W(DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .enable_transfer(enable_transfer),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_src(out_src),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic e,
                               input logic o, input logic [31:0] d);
    @(negedge clk);
    rst             = r;
    in_valid        = v;
    enable_transfer = e;
    out_ready       = o;
    in_data         = d;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] ei, input logic eov,
                             input logic [7:0] eod, input logic [1:0] eos, input logic eb);
    cmp({tag, " in_ready"}, in_ready, ei);
    cmp({tag, " out_valid"}, out_valid, eov);
    cmp({tag, " busy"}, busy, eb);
    // Payload is only meaningful with out_valid high, or under reset where it must be 0.
    if (eov || rst) begin
      cmp({tag, " out_data"}, out_data, eod);
      cmp({tag, " out_src"}, out_src, eos);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [3:0] v, input logic e,
                      input logic o, input logic [7:0] d, input logic [3:0] ei,
                      input logic eov, input logic [7:0] eod, input logic [1:0] eos,
                      input logic eb);
    applyStimulus(r, v, e, o, {4{d}});
    checkOutput(tag, ei, eov, eod, eos, eb);
  endtask

  task automatic addVec(input logic r, input logic [3:0] v, input logic e, input logic o,
                        input logic [3:0] ei, input logic eov, input logic [7:0] eod,
                        input logic [1:0] eos, input logic eb);
    vec_t t;
    t.r = r; t.v = v; t.e = e; t.o = o;
    t.ei = ei; t.eov = eov; t.eod = eod; t.eos = eos; t.eb = eb;
    vecs.push_back(t);
  endtask

  initial begin
    logic [31:0] d;

    // Rows 0-24: all four channels requesting, four-beat bursts rotating 0,1,2,3,0.
    addVec(1, 4'hF, 1, 1, 4'h0, 0, 8'h00, 2'd0, 0);  // 0 reset
    addVec(0, 4'hF, 1, 1, 4'h0, 0, 8'h00, 2'd0, 0);  // 1 idle, picks ch0
    addVec(0, 4'hF, 1, 1, 4'h1, 0, 8'h00, 2'd0, 1);  // 2
    addVec(0, 4'hF, 1, 1, 4'h1, 1, 8'h02, 2'd0, 1);  // 3
    addVec(0, 4'hF, 1, 1, 4'h1, 1, 8'h03, 2'd0, 1);  // 4
    addVec(0, 4'hF, 1, 1, 4'h1, 1, 8'h04, 2'd0, 1);  // 5 last beat of ch0
    addVec(0, 4'hF, 1, 1, 4'h0, 1, 8'h05, 2'd0, 1);  // 6 idle gap
    addVec(0, 4'hF, 1, 1, 4'h2, 0, 8'h00, 2'd0, 1);  // 7 ch1 granted
    addVec(0, 4'hF, 1, 1, 4'h2, 1, 8'h47, 2'd1, 1);  // 8
    addVec(0, 4'hF, 1, 1, 4'h2, 1, 8'h48, 2'd1, 1);  // 9
    addVec(0, 4'hF, 1, 1, 4'h2, 1, 8'h49, 2'd1, 1);  // 10
    addVec(0, 4'hF, 1, 1, 4'h0, 1, 8'h4A, 2'd1, 1);  // 11
    addVec(0, 4'hF, 1, 1, 4'h4, 0, 8'h00, 2'd0, 1);  // 12 ch2 granted
    addVec(0, 4'hF, 1, 1, 4'h4, 1, 8'h8C, 2'd2, 1);  // 13
    addVec(0, 4'hF, 1, 1, 4'h4, 1, 8'h8D, 2'd2, 1);  // 14
    addVec(0, 4'hF, 1, 1, 4'h4, 1, 8'h8E, 2'd2, 1);  // 15
    addVec(0, 4'hF, 1, 1, 4'h0, 1, 8'h8F, 2'd2, 1);  // 16
    addVec(0, 4'hF, 1, 1, 4'h8, 0, 8'h00, 2'd0, 1);  // 17 ch3 granted
    addVec(0, 4'hF, 1, 1, 4'h8, 1, 8'hD1, 2'd3, 1);  // 18
    addVec(0, 4'hF, 1, 1, 4'h8, 1, 8'hD2, 2'd3, 1);  // 19
    addVec(0, 4'hF, 1, 1, 4'h8, 1, 8'hD3, 2'd3, 1);  // 20
    addVec(0, 4'hF, 1, 1, 4'h0, 1, 8'hD4, 2'd3, 1);  // 21
    addVec(0, 4'hF, 1, 1, 4'h1, 0, 8'h00, 2'd0, 1);  // 22 wraps back to ch0
    addVec(0, 4'h0, 1, 1, 4'h1, 1, 8'h16, 2'd0, 1);  // 23 valid dropped, rr_ptr -> 1
    addVec(0, 4'h0, 1, 1, 4'h0, 0, 8'h00, 2'd0, 0);  // 24
    // Rows 25-34: ch2 sends two beats and drops; the rr_ptr=3 scan wraps to ch1; then ch3 wins from rr_ptr=2.
    addVec(0, 4'h4, 1, 1, 4'h0, 0, 8'h00, 2'd0, 0);  // 25
    addVec(0, 4'h4, 1, 1, 4'h4, 0, 8'h00, 2'd0, 1);  // 26
    addVec(0, 4'h4, 1, 1, 4'h4, 1, 8'h9A, 2'd2, 1);  // 27
    addVec(0, 4'h0, 1, 1, 4'h4, 1, 8'h9B, 2'd2, 1);  // 28 ch2 drops, rr_ptr -> 3
    addVec(0, 4'h2, 1, 1, 4'h0, 0, 8'h00, 2'd0, 0);  // 29 scan 3,0,1 -> ch1
    addVec(0, 4'h2, 1, 1, 4'h2, 0, 8'h00, 2'd0, 1);  // 30
    addVec(0, 4'h0, 1, 1, 4'h2, 1, 8'h5E, 2'd1, 1);  // 31 rr_ptr -> 2
    addVec(0, 4'hB, 1, 1, 4'h0, 0, 8'h00, 2'd0, 0);  // 32 scan 2,3 -> ch3
    addVec(0, 4'h0, 1, 1, 4'h8, 0, 8'h00, 2'd0, 1);  // 33
    addVec(0, 4'h0, 1, 1, 4'h0, 0, 8'h00, 2'd0, 0);  // 34

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < 4; c++) d[c*8 +: 8] = 8'(c*64 + i);
      applyStimulus(vecs[i].r, vecs[i].v, vecs[i].e, vecs[i].o, d);
      checkOutput($sformatf("vec%0d", i), vecs[i].ei, vecs[i].eov, vecs[i].eod,
                  vecs[i].eos, vecs[i].eb);
    end

    // Back-pressure: two beats fill the buffer, the head holds, then the beats drain in order.
    // H7/H8 push and pop in the same cycle at count 1.
    step("Hrst", 1, 4'h0, 1, 1, 8'h00, 4'h0, 0, 8'h00, 2'd0, 0);
    step("H1",   0, 4'h1, 1, 0, 8'h11, 4'h0, 0, 8'h00, 2'd0, 0);
    step("H2",   0, 4'h1, 1, 0, 8'h12, 4'h1, 0, 8'h00, 2'd0, 1);
    step("H3",   0, 4'h1, 1, 0, 8'h13, 4'h1, 1, 8'h12, 2'd0, 1);
    step("H4",   0, 4'h1, 1, 0, 8'h14, 4'h0, 1, 8'h12, 2'd0, 1);
    step("H5",   0, 4'h1, 1, 0, 8'h14, 4'h0, 1, 8'h12, 2'd0, 1);
    step("H6",   0, 4'h1, 1, 1, 8'h14, 4'h0, 1, 8'h12, 2'd0, 1);
    step("H7",   0, 4'h1, 1, 1, 8'h14, 4'h1, 1, 8'h13, 2'd0, 1);
    step("H8",   0, 4'h1, 1, 1, 8'h15, 4'h1, 1, 8'h14, 2'd0, 1);
    step("H9",   0, 4'h0, 1, 1, 8'h15, 4'h0, 1, 8'h15, 2'd0, 1);
    step("H10",  0, 4'h0, 1, 1, 8'h00, 4'h0, 0, 8'h00, 2'd0, 0);

    // enable_transfer drops after beat 2. The buffer drains and the grant is
    // held; beats 3 and 4 follow once enable returns.
    step("Erst", 1, 4'h0, 1, 1, 8'h00, 4'h0, 0, 8'h00, 2'd0, 0);
    step("E1",   0, 4'h1, 1, 1, 8'h21, 4'h0, 0, 8'h00, 2'd0, 0);
    step("E2",   0, 4'h1, 1, 1, 8'h22, 4'h1, 0, 8'h00, 2'd0, 1);
    step("E3",   0, 4'h1, 1, 0, 8'h23, 4'h1, 1, 8'h22, 2'd0, 1);
    step("E4",   0, 4'h1, 0, 0, 8'h24, 4'h0, 1, 8'h22, 2'd0, 1);
    step("E5",   0, 4'h1, 0, 1, 8'h24, 4'h0, 1, 8'h22, 2'd0, 1);
    step("E6",   0, 4'h1, 0, 1, 8'h24, 4'h0, 1, 8'h23, 2'd0, 1);
    step("E7",   0, 4'h1, 0, 1, 8'h24, 4'h0, 0, 8'h00, 2'd0, 1);
    step("E8",   0, 4'h1, 1, 1, 8'h24, 4'h1, 0, 8'h00, 2'd0, 1);
    step("E9",   0, 4'h1, 1, 1, 8'h25, 4'h1, 1, 8'h24, 2'd0, 1);
    step("E10",  0, 4'h0, 1, 1, 8'h25, 4'h0, 1, 8'h25, 2'd0, 1);
    step("E11",  0, 4'h0, 1, 1, 8'h00, 4'h0, 0, 8'h00, 2'd0, 0);

    // rr_ptr is 1 at this point, so ch1 wins. Reset is asserted with two
    // beats buffered and is checked before any clock edge. After release the
    // scan starts at 0, and no stale beat reappears.
    step("R1",   0, 4'h3, 1, 0, 8'h31, 4'h0, 0, 8'h00, 2'd0, 0);
    step("R2",   0, 4'h3, 1, 0, 8'h32, 4'h2, 0, 8'h00, 2'd0, 1);
    step("R3",   0, 4'h3, 1, 0, 8'h33, 4'h2, 1, 8'h32, 2'd1, 1);
    step("R4",   0, 4'h3, 1, 0, 8'h34, 4'h0, 1, 8'h32, 2'd1, 1);
    step("R5",   1, 4'h3, 1, 0, 8'h34, 4'h0, 0, 8'h00, 2'd0, 0);
    step("R6",   0, 4'h3, 1, 1, 8'h35, 4'h0, 0, 8'h00, 2'd0, 0);
    step("R7",   0, 4'h3, 1, 1, 8'h36, 4'h1, 0, 8'h00, 2'd0, 1);
    step("R8",   0, 4'h0, 1, 1, 8'h36, 4'h1, 1, 8'h36, 2'd0, 1);
    step("R9",   0, 4'h0, 1, 1, 8'h00, 4'h0, 0, 8'h00, 2'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of requester channels (2..16).
REQ-002 SHALL have parameter DATA_W, default 32, payload width per channel.
REQ-003 SHALL have parameter MAX_BURST, default 4, max beats per grant (1..255).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid  input  N_IN  per-requester beat valid.
REQ-007 SHALL have port in_ready  output  N_IN  per-requester accept.
REQ-008 SHALL have port in_data  input  N_IN*DATA_W  payloads, channel i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port enable_transfer  input  1  high permits acceptance and new grants.
REQ-010 SHALL have port out_valid  output  1  output beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port out_data  output  DATA_W  head beat payload.
REQ-013 SHALL have port out_src  output  max(1,clog2(N_IN))  source channel of head beat.
REQ-014 SHALL have port busy  output  1  high when FSM in GRANT or buffer non-empty.

Function
REQ-015 SHALL define in_transfer[i] = in_valid[i] & in_ready[i]; out_transfer = out_valid & out_ready.
REQ-016 SHALL implement FSM states IDLE and GRANT plus registers grant_idx, rr_ptr, burst_cnt.
REQ-017 SHALL, in IDLE with enable_transfer high and any in_valid, select first asserted in_valid scanning rr_ptr, rr_ptr+1, ... mod N_IN, load grant_idx, clear burst_cnt, enter GRANT next cycle.
REQ-018 SHALL stay in IDLE while enable_transfer low or no in_valid asserted; rr_ptr unchanged.
REQ-019 SHALL drive in_ready[i] = (state==GRANT) & (i==grant_idx) & enable_transfer & (count<2); all others 0; no combinational path from out_ready.
REQ-020 SHALL increment burst_cnt on each in_transfer; when the transfer makes burst_cnt reach MAX_BURST, return to IDLE and set rr_ptr = (grant_idx+1) mod N_IN.
REQ-021 SHALL, in GRANT, return to IDLE with rr_ptr = (grant_idx+1) mod N_IN on any cycle where in_valid[grant_idx] is low.
REQ-022 SHALL hold state, grant_idx and burst_cnt unchanged while enable_transfer low in GRANT.
REQ-023 SHALL hold a 2-entry FIFO (head + skid) of {payload, source}; count 0..2.
REQ-024 SHALL drive out_valid = (count!=0); out_data/out_src from head entry, stable while out_valid & !out_ready.
REQ-025 SHALL update count: +1 on in_transfer only, -1 on out_transfer only, unchanged on both or neither; entry order preserved.
REQ-026 SHALL give latency of one cycle from in_transfer to out_valid when count was 0.
REQ-027 SHALL sustain one beat per cycle from one granted requester when out_ready held high.
REQ-028 SHALL never overflow (count==2 forces in_ready low) nor underflow; out_transfer independent of enable_transfer.
REQ-029 SHALL drop no beat and duplicate no beat across grant changes.

Reset
REQ-030 SHALL, on rst high, asynchronously force state IDLE, rr_ptr 0, grant_idx 0, burst_cnt 0, count 0, out_valid 0, in_ready all 0, busy 0; out_data/out_src 0.
REQ-031 SHALL discard buffered beats and any grant on reset mid-operation; first grant after release follows REQ-017 from rr_ptr 0.

Verification
REQ-032 SHALL test: all 4 in_valid high, out_ready high, MAX_BURST 4 -> grants 0,1,2,3,0 each 4 consecutive beats, one idle cycle between grants, out_src matches.
REQ-033 SHALL test: ch2 only, sends 2 beats then drops valid -> grant ends, rr_ptr=3; next ch1 request granted after ch3 absent, rr_ptr scan wraps.
REQ-034 SHALL test: out_ready low with ch0 streaming -> exactly 2 beats accepted, in_ready[0] low, out_data held; out_ready high -> beats emerge in order, no loss.
REQ-035 SHALL test: enable_transfer low mid-burst after beat 2 -> in_ready 0, buffered beats still drain, burst resumes at beat 3 when enable returns.
REQ-036 SHALL test: rst asserted with count 2 in GRANT -> out_valid and in_ready 0 immediately (same cycle, no clock edge), busy 0.
REQ-037 SHALL test: simultaneous in_transfer and out_transfer at count 1 -> count remains 1, payload order correct.
